// File: rtl/amp_mod_scheduler.sv
// Round-robin scheduler that shares one DSP multiplier among NUM_CH voice channels
// for amplitude modulation (carrier * modulator, Q(DATA_WIDTH-1) scaling, saturated).
module amp_mod_scheduler #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_CH-1:0]              ch_en_i,
  input  logic [NUM_CH-1:0]              req_valid_i,
  output logic [NUM_CH-1:0]              req_ready_o,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   carrier_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   mod_i,
  input  logic                           flush_i,
  output logic [17:0]                    mul_a_o,
  output logic [17:0]                    mul_b_o,
  input  logic [35:0]                    mul_p_i,
  output logic                           res_valid_o,
  output logic [$clog2(NUM_CH)-1:0]      res_ch_o,
  output logic [DATA_WIDTH-1:0]          res_data_o,
  output logic                           busy_o,
  output logic                           flush_done_o
);

  localparam int unsigned CH_W = $clog2(NUM_CH);
  localparam int unsigned P_W  = 36;
  localparam logic signed [P_W-1:0] SAT_MAX = P_W'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [P_W-1:0] SAT_MIN = -SAT_MAX - 36'sd1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

  state_e                              state_q, state_d;
  logic                                flush_done_d;
  logic [CH_W-1:0]                     rr_q;
  logic [NUM_CH-1:0]                   elig;
  logic                                grant_en;
  logic                                grant_any;
  logic [CH_W-1:0]                     grant_ch;
  logic [NUM_CH-1:0]                   grant_oh;
  int unsigned                         idx;
  logic signed [DATA_WIDTH-1:0]        sel_mod, sel_car;
  logic                                op_v;
  logic [CH_W-1:0]                     op_ch;
  logic [MUL_LATENCY-1:0]              tag_v;
  logic [MUL_LATENCY-1:0][CH_W-1:0]    tag_ch;
  logic                                in_flight;
  logic signed [P_W-1:0]               p_shift;
  logic [DATA_WIDTH-1:0]               sat_data;

  assign elig        = ch_en_i & req_valid_i;
  assign in_flight   = op_v | (|tag_v);
  assign busy_o      = (state_q != IDLE) | in_flight;
  assign req_ready_o = grant_oh;

  // Round-robin pick starting at rr_q; suppressed during reset, flush and drain.
  always_comb begin : arbiter
    grant_en  = rst_ni && !flush_i && (state_q != DRAIN);
    grant_any = 1'b0;
    grant_ch  = '0;
    grant_oh  = '0;
    idx       = 0;
    sel_mod   = '0;
    sel_car   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (grant_en && !grant_any && elig[CH_W'(idx)]) begin
        grant_any = 1'b1;
        grant_ch  = CH_W'(idx);
      end
    end
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (grant_any && (grant_ch == CH_W'(k))) begin
        grant_oh[k] = 1'b1;
        sel_mod     = mod_i[k*DATA_WIDTH +: DATA_WIDTH];
        sel_car     = carrier_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin : next_state
    state_d      = state_q;
    flush_done_d = 1'b0;
    if (flush_i) begin
      state_d = DRAIN;
    end else begin
      unique case (state_q)
        IDLE:    if (|elig) state_d = ACTIVE;
        ACTIVE:  if (!(|elig) && !in_flight) state_d = IDLE;
        DRAIN: begin
          if (!in_flight) begin
            state_d      = IDLE;
            flush_done_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin : state_reg
    if (!rst_ni) begin
      state_q      <= IDLE;
      flush_done_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_done_o <= flush_done_d;
    end
  end

  // Scale back to sample range and clamp.
  always_comb begin : saturate
    p_shift = $signed(mul_p_i) >>> (DATA_WIDTH - 1);
    if (p_shift > SAT_MAX)      sat_data = SAT_MAX[DATA_WIDTH-1:0];
    else if (p_shift < SAT_MIN) sat_data = SAT_MIN[DATA_WIDTH-1:0];
    else                        sat_data = p_shift[DATA_WIDTH-1:0];
  end

  // Operand issue, tag pipeline aligned with the multiplier, and result register.
  always_ff @(posedge clk_i) begin : datapath
    if (!rst_ni) begin
      rr_q        <= '0;
      op_v        <= 1'b0;
      op_ch       <= '0;
      mul_a_o     <= '0;
      mul_b_o     <= '0;
      tag_v       <= '0;
      tag_ch      <= '0;
      res_valid_o <= 1'b0;
      res_ch_o    <= '0;
      res_data_o  <= '0;
    end else begin
      op_v  <= grant_any;
      op_ch <= grant_ch;
      if (grant_any) begin
        mul_a_o <= 18'(sel_mod);
        mul_b_o <= 18'(sel_car);
        rr_q    <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : CH_W'(grant_ch + 1'b1);
      end else begin
        mul_a_o <= '0;
        mul_b_o <= '0;
      end
      tag_v[0]  <= op_v;
      tag_ch[0] <= op_ch;
      for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_ch[i] <= tag_ch[i-1];
      end
      res_valid_o <= tag_v[MUL_LATENCY-1];
      if (tag_v[MUL_LATENCY-1]) begin
        res_ch_o   <= tag_ch[MUL_LATENCY-1];
        res_data_o <= sat_data;
      end
    end
  end

endmodule

// File: tb/tb_amp_mod_scheduler.sv
// Scoreboard bench for amp_mod_scheduler with a behavioural 2-stage multiplier.
module tb_amp_mod_scheduler;
  localparam int unsigned DW  = 16;
  localparam int unsigned NCH = 4;
  localparam int unsigned LAT = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [NCH-1:0]    ch_en_i = '0;
  logic [NCH-1:0]    req_valid_i = '0;
  logic [NCH-1:0]    req_ready_o;
  logic [NCH*DW-1:0] carrier_i = '0;
  logic [NCH*DW-1:0] mod_i = '0;
  logic              flush_i = 1'b0;
  logic [17:0]       mul_a_o, mul_b_o;
  logic [35:0]       mul_p_i;
  logic              res_valid_o;
  logic [1:0]        res_ch_o;
  logic [DW-1:0]     res_data_o;
  logic              busy_o, flush_done_o;

  always #5 clk_i = ~clk_i;

  amp_mod_scheduler #(.DATA_WIDTH(DW), .NUM_CH(NCH), .MUL_LATENCY(LAT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ch_en_i(ch_en_i), .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o), .carrier_i(carrier_i), .mod_i(mod_i), .flush_i(flush_i),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_p_i(mul_p_i), .res_valid_o(res_valid_o),
    .res_ch_o(res_ch_o), .res_data_o(res_data_o), .busy_o(busy_o), .flush_done_o(flush_done_o)
  );

  // Shared DSP multiplier model with LAT cycles of latency.
  logic signed [35:0] p1, p2;
  always @(posedge clk_i) begin
    p1 <= $signed(mul_a_o) * $signed(mul_b_o);
    p2 <= p1;
  end
  assign mul_p_i = p2;

  typedef struct {int ch; int data; int cyc;} exp_t;
  exp_t sb[$];
  int   grant_log[$];
  int   res_log[$];
  int   res_ch_log[$];
  int   res_cyc_log[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   fd_pulses = 0;
  logic [DW-1:0] prev_data = '0;
  logic [1:0]    prev_ch = '0;
  logic          rst_prev = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic int model(input int c, input int m);
    longint p;
    p = longint'(c) * longint'(m);
    p = p >>> 15;
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    return int'(p);
  endfunction

  // Monitor: handshakes push expectations, results pop and compare.
  always @(negedge clk_i) begin
    exp_t e;
    for (int k = 0; k < NCH; k++) begin
      if (req_valid_i[k] && req_ready_o[k]) begin
        checks++;
        if (!ch_en_i[k] || $countones(req_ready_o) != 1) begin
          failures++;
          $display("FAIL grant_legal: ready=%b en=%b", req_ready_o, ch_en_i);
        end
        e.ch   = k;
        e.data = model($signed(carrier_i[k*DW +: DW]), $signed(mod_i[k*DW +: DW]));
        e.cyc  = cyc + 2 + LAT;
        sb.push_back(e);
        grant_log.push_back(k);
      end
    end
    if (res_valid_o) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: ch=%0d data=%0d cyc=%0d", res_ch_o, $signed(res_data_o), cyc);
      end else begin
        e = sb.pop_front();
        if (int'(res_ch_o) !== e.ch || int'($signed(res_data_o)) !== e.data || cyc !== e.cyc) begin
          failures++;
          $display("FAIL result: got ch=%0d data=%0d cyc=%0d, expected ch=%0d data=%0d cyc=%0d",
                   res_ch_o, $signed(res_data_o), cyc, e.ch, e.data, e.cyc);
        end
      end
      res_log.push_back(int'($signed(res_data_o)));
      res_ch_log.push_back(int'(res_ch_o));
      res_cyc_log.push_back(cyc);
    end else if (rst_prev) begin
      checks++;
      if (res_data_o !== prev_data || res_ch_o !== prev_ch) begin
        failures++;
        $display("FAIL result_hold: got ch=%0d data=%0h, expected ch=%0d data=%0h",
                 res_ch_o, res_data_o, prev_ch, prev_data);
      end
    end
    if (flush_done_o) fd_pulses++;
    prev_data = res_data_o;
    prev_ch   = res_ch_o;
    rst_prev  = rst_ni;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_logs();
    sb.delete(); grant_log.delete(); res_log.delete(); res_ch_log.delete(); res_cyc_log.delete();
    fd_pulses = 0;
  endtask

  task automatic do_reset();
    req_valid_i = '0; flush_i = 1'b0; rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    clear_logs();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy_o) && n < 50) begin tick(); n++; end
    tick();
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL %s_drain_timeout: pending=%0d busy=%0b, expected 0/0", name, sb.size(), busy_o);
    end
  endtask

  task automatic test_reset();
    ch_en_i = '1; req_valid_i = '1;
    carrier_i = {NCH{16'h1234}}; mod_i = {NCH{16'h4321}};
    tick(); tick();
    checks++;
    if (req_ready_o !== 4'b0 || res_valid_o !== 1'b0 || res_data_o !== '0 || res_ch_o !== '0 ||
        mul_a_o !== '0 || mul_b_o !== '0 || flush_done_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b rv=%b rd=%h rc=%0d a=%h b=%h fd=%b busy=%b, expected all 0",
               req_ready_o, res_valid_o, res_data_o, res_ch_o, mul_a_o, mul_b_o, flush_done_o, busy_o);
    end
    req_valid_i = '0;
    rst_ni = 1'b1;
    tick();
    clear_logs();
  endtask

  task automatic test_single();
    carrier_i[1*DW +: DW] = 16'sd16384;
    mod_i[1*DW +: DW]     = 16'sd16384;
    req_valid_i = 4'b0010;
    #1;
    checks++;
    if (req_ready_o !== 4'b0010) begin
      failures++; $display("FAIL single_ready: got %b, expected 0010", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    checks++;
    if (mul_a_o !== 18'sd16384 || mul_b_o !== 18'sd16384) begin
      failures++; $display("FAIL single_operands: got a=%0d b=%0d, expected 16384/16384", $signed(mul_a_o), $signed(mul_b_o));
    end
    drain("single");
    checks++;
    if (res_log.size() != 1 || res_log[0] != 8192 || res_ch_log[0] != 1) begin
      failures++; $display("FAIL single_result: got n=%0d, expected one result ch=1 data=8192", res_log.size());
    end
    clear_logs();
  endtask

  task automatic test_saturate();
    carrier_i[2*DW +: DW] = 16'h8000; mod_i[2*DW +: DW] = 16'h8000;
    req_valid_i = 4'b0100;
    tick();
    mod_i[2*DW +: DW] = 16'h7fff;
    tick();
    req_valid_i = '0;
    drain("saturate");
    checks++;
    if (res_log.size() != 2 || res_log[0] != 32767 || res_log[1] != -32767) begin
      failures++; $display("FAIL saturate: got n=%0d, expected 32767 then -32767", res_log.size());
    end
    clear_logs();
  endtask

  task automatic test_round_robin();
    do_reset();
    ch_en_i = '1; req_valid_i = '1;
    for (int i = 0; i < 12; i++) begin
      carrier_i = {$urandom, $urandom};
      mod_i     = {$urandom, $urandom};
      tick();
    end
    req_valid_i = '0;
    drain("round_robin");
    checks++;
    if (grant_log.size() != 12 || res_log.size() != 12) begin
      failures++; $display("FAIL rr_count: got grants=%0d results=%0d, expected 12/12", grant_log.size(), res_log.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (grant_log[i] != i % 4 || res_ch_log[i] != i % 4 || res_cyc_log[i] != res_cyc_log[0] + i) begin
          failures++;
          $display("FAIL rr_order[%0d]: got grant=%0d res_ch=%0d cyc=%0d, expected %0d/%0d/%0d",
                   i, grant_log[i], res_ch_log[i], res_cyc_log[i], i % 4, i % 4, res_cyc_log[0] + i);
        end
      end
    end
    clear_logs();
  endtask

  task automatic test_enable_mask();
    do_reset();
    ch_en_i = 4'b1010; req_valid_i = '1;
    for (int i = 0; i < 8; i++) tick();
    req_valid_i = '0;
    drain("enable_mask");
    checks++;
    if (grant_log.size() != 8) begin
      failures++; $display("FAIL mask_count: got %0d grants, expected 8", grant_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (grant_log[i] != ((i % 2 == 0) ? 1 : 3)) begin
          failures++; $display("FAIL mask_order[%0d]: got %0d, expected %0d", i, grant_log[i], (i % 2 == 0) ? 1 : 3);
        end
      end
    end
    ch_en_i = '1;
    clear_logs();
  endtask

  task automatic test_flush();
    do_reset();
    ch_en_i = '1; req_valid_i = '1;
    tick(); tick();
    flush_i = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 4'b0) begin
      failures++; $display("FAIL flush_no_grant: got %b, expected 0000", req_ready_o);
    end
    tick();
    flush_i = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 4'b0 || busy_o !== 1'b1) begin
      failures++; $display("FAIL drain_no_grant: got ready=%b busy=%b, expected 0000/1", req_ready_o, busy_o);
    end
    tick();
    req_valid_i = '0;
    drain("flush");
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (grant_log.size() != 2 || res_log.size() != 2 || fd_pulses != 1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_summary: got grants=%0d results=%0d pulses=%0d busy=%b, expected 2/2/1/0",
               grant_log.size(), res_log.size(), fd_pulses, busy_o);
    end
    clear_logs();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    ch_en_i = '1; req_valid_i = 4'b0100;
    tick();
    req_valid_i = '0; rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    clear_logs();
    req_valid_i = '1;
    #1;
    checks++;
    if (req_ready_o !== 4'b0001) begin
      failures++; $display("FAIL rr_after_reset: got %b, expected 0001", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (res_log.size() != 1 || grant_log.size() != 1 || res_ch_log[0] != 0) begin
      failures++; $display("FAIL reset_discard: got results=%0d grants=%0d, expected 1/1 on ch0", res_log.size(), grant_log.size());
    end
    clear_logs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturate();
    test_round_robin();
    test_enable_mask();
    test_flush();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
